// File: rtl/pgm_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, hides the 1-cycle program-memory read latency
// and issues words over valid/ready. Optional single-step mode: PGM_SINGLE_STEP_EN.
module pgm_fetch_ctrl #(
    parameter int                 ADDR_W    = 5,
    parameter int                 INSTR_W   = 15,
    parameter logic [INSTR_W-1:0] HALT_WORD = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt_req,
`ifdef PGM_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic [ADDR_W-1:0]  adp_bus,
    output logic               rd,
    output logic               wr,
    input  logic [INSTR_W-1:0] pgm_line,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic               running,
    output logic               done
);

`ifdef PGM_SINGLE_STEP_EN
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ISSUE, STEPWAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, ISSUE} state_t;
`endif

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    npc_q, npc_d;
    logic [ADDR_W-1:0]    adp_q, adp_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 vld_q, vld_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic                 done_q, done_d;
    logic                 rd_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            npc_q   <= '0;
            adp_q   <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
            adp_q   <= adp_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        npc_d   = npc_q;
        adp_d   = adp_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        pc_d    = pc_q;
        done_d  = 1'b0;
        rd_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    npc_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rd_c    = 1'b1;
                adp_d   = npc_q;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                instr_d = pgm_line;
                pc_d    = npc_q;
                if (pgm_line == HALT_WORD) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    vld_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    npc_d = br_taken ? br_addr : pc_q + 1'b1;
                    vld_d = 1'b0;
                    if (halt_req)
                        state_d = IDLE;
                    else
`ifdef PGM_SINGLE_STEP_EN
                        state_d = STEPWAIT;
`else
                        state_d = FETCH;
`endif
                end
            end
`ifdef PGM_SINGLE_STEP_EN
            STEPWAIT: begin
                if (halt_req)
                    state_d = IDLE;
                else if (step)
                    state_d = FETCH;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Address is live from npc during FETCH, otherwise the last fetched address is held.
    assign adp_bus     = rd_c ? npc_q : adp_q;
    assign rd          = rd_c;
    assign wr          = 1'b0;
    assign instr       = instr_q;
    assign instr_valid = vld_q;
    assign pc          = pc_q;
    assign running     = (state_q != IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_pgm_fetch_ctrl.sv
// Scoreboard bench for pgm_fetch_ctrl: directed programs, monitor checks every handshake.
module tb_pgm_fetch_ctrl;
    localparam int AW = 5;
    localparam int IW = 15;
`ifdef PGM_SINGLE_STEP_EN
    localparam int GAP = 4;
`else
    localparam int GAP = 3;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic          instr_ready = 1'b0;
    logic          br_taken = 1'b0;
    logic [AW-1:0] br_addr = '0;
    logic [IW-1:0] pgm_line = '0;
    logic [AW-1:0] adp_bus, pc;
    logic          rd, wr, instr_valid, running, done;
    logic [IW-1:0] instr;
`ifdef PGM_SINGLE_STEP_EN
    logic          auto_step = 1'b1;
    logic          step_p = 1'b0;
    logic          step;
    assign step = auto_step | step_p;
`endif

    logic [IW-1:0] mem [32];
    int checks = 0, errors = 0, cyc = 0, last_hs = 0;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
        int            gap;
    } exp_t;
    exp_t sb[$];

    pgm_fetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
`ifdef PGM_SINGLE_STEP_EN
        .step(step),
`endif
        .adp_bus(adp_bus), .rd(rd), .wr(wr), .pgm_line(pgm_line),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .br_taken(br_taken), .br_addr(br_addr), .pc(pc),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous program memory model: data valid the cycle after rd.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rd) pgm_line <= mem[adp_bus];
    end

    function automatic logic [IW-1:0] word(int a);
        return IW'(a * 97 + 3);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("done_valid_excl", {31'b0, done & instr_valid}, 0);
            chk("wr_zero", {31'b0, wr}, 0);
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL hs_unexpected: got pc %0d instr %0h expected no handshake", pc, instr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("hs_pc", {27'b0, pc}, {27'b0, e.pc});
                    chk("hs_instr", {17'b0, instr}, {17'b0, e.instr});
                    if (e.gap != 0) chk("hs_gap", cyc - last_hs, e.gap);
                end
                last_hs = cyc;
            end
        end
    end

    task automatic push(int p, int gap);
        exp_t e;
        e.pc = AW'(p);
        e.instr = mem[p];
        e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(string name);
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        chk(name, {31'b0, instr_valid}, 1);
    endtask

    task automatic wait_rd(string name);
        for (int i = 0; i < 20 && !rd; i++) tick();
        chk(name, {31'b0, rd}, 1);
    endtask

    task automatic handshake();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_adp"}, {27'b0, adp_bus}, 0);
        chk({tag, "_rd"}, {31'b0, rd}, 0);
        chk({tag, "_wr"}, {31'b0, wr}, 0);
        chk({tag, "_instr"}, {17'b0, instr}, 0);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 0);
        chk({tag, "_pc"}, {27'b0, pc}, 0);
        chk({tag, "_running"}, {31'b0, running}, 0);
        chk({tag, "_done"}, {31'b0, done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        for (int a = 0; a < 32; a++) mem[a] = word(a);
        mem[4] = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_outs("reset");

        // Free-running program 0..3, halt word at 4.
        push(0, 0); push(1, GAP); push(2, GAP); push(3, GAP);
        instr_ready = 1'b1;
        pulse_start();
        chk("t1_fetch_rd", {31'b0, rd}, 1);
        chk("t1_fetch_adp", {27'b0, adp_bus}, 0);
        tick();
        chk("t1_capture_rd", {31'b0, rd}, 0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dcnt++;
        end
        instr_ready = 1'b0;
        chk("t1_done_pulses", dcnt, 1);
        chk("t1_running", {31'b0, running}, 0);
        chk("t1_drain", sb.size(), 0);

        // Stall at pc=2 for five cycles.
        push(0, 0); push(1, 0); push(2, 0); push(3, 0);
        pulse_start();
        wait_valid("t2_v0"); handshake();
        wait_valid("t2_v1"); handshake();
        wait_valid("t2_v2");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_instr", {17'b0, instr}, {17'b0, word(2)});
            chk("t2_hold_pc", {27'b0, pc}, 2);
            chk("t2_hold_rd", {31'b0, rd}, 0);
            chk("t2_hold_valid", {31'b0, instr_valid}, 1);
        end
        handshake();
        wait_rd("t2_refetch_rd");
        chk("t2_refetch_adp", {27'b0, adp_bus}, 3);
        wait_valid("t2_v3"); handshake();
        for (int i = 0; i < 20 && !done; i++) tick();
        chk("t2_done", {31'b0, done}, 1);
        tick();
        chk("t2_running", {31'b0, running}, 0);

        // Branch at pc=5 to 20; a stray br_taken at pc=4 is ignored.
        mem[4] = word(4);
        for (int k = 0; k < 6; k++) push(k, 0);
        push(20, 0);
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            wait_valid("t3_v");
            if (k == 4) begin
                br_taken = 1'b1; br_addr = 5'd9;
                tick(); tick();
                br_taken = 1'b0;
            end
            handshake();
        end
        wait_valid("t3_v5");
        br_taken = 1'b1; br_addr = 5'd20;
        handshake();
        br_taken = 1'b0;
        wait_rd("t3_br_rd");
        chk("t3_br_adp", {27'b0, adp_bus}, 20);
        wait_valid("t3_v20");
        chk("t3_pc20", {27'b0, pc}, 20);
        halt_req = 1'b1; handshake(); halt_req = 1'b0;
        chk("t3_running", {31'b0, running}, 0);

        // PC wrap from 31 to 0.
        push(0, 0); push(31, 0); push(0, 0);
        pulse_start();
        wait_valid("t4_v0");
        br_taken = 1'b1; br_addr = 5'd31;
        handshake();
        br_taken = 1'b0;
        wait_valid("t4_v31"); handshake();
        wait_rd("t4_wrap_rd");
        chk("t4_wrap_adp", {27'b0, adp_bus}, 0);
        wait_valid("t4_vwrap");
        halt_req = 1'b1; handshake(); halt_req = 1'b0;
        chk("t4_running", {31'b0, running}, 0);

        // halt_req raised during CAPTURE: in-flight word still issued.
        push(0, 0);
        pulse_start();
        tick();
        halt_req = 1'b1; instr_ready = 1'b1;
        tick();
        chk("t5_valid", {31'b0, instr_valid}, 1);
        tick();
        instr_ready = 1'b0; halt_req = 1'b0;
        chk("t5_running", {31'b0, running}, 0);
        chk("t5_valid_off", {31'b0, instr_valid}, 0);
        tick(); tick();
        chk("t5_no_rd", {31'b0, rd}, 0);

        // Restart from 0, then reset while instr_valid is high.
        pulse_start();
        chk("t6_restart_adp", {27'b0, adp_bus}, 0);
        wait_valid("t6_v0");
        chk("t6_pc0", {27'b0, pc}, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset_outs("t6_rst");
        push(0, 0);
        pulse_start();
        chk("t6_post_rd", {31'b0, rd}, 1);
        chk("t6_post_adp", {27'b0, adp_bus}, 0);
        wait_valid("t6_v");
        halt_req = 1'b1; handshake(); halt_req = 1'b0;

`ifdef PGM_SINGLE_STEP_EN
        // One instruction per step pulse.
        auto_step = 1'b0;
        push(0, 0); push(1, 0);
        pulse_start();
        wait_valid("ss_v0"); handshake();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ss_wait_rd", {31'b0, rd}, 0);
            chk("ss_wait_run", {31'b0, running}, 1);
        end
        step_p = 1'b1; tick(); step_p = 1'b0;
        chk("ss_fetch_rd", {31'b0, rd}, 1);
        chk("ss_fetch_adp", {27'b0, adp_bus}, 1);
        wait_valid("ss_v1");
        halt_req = 1'b1; handshake(); halt_req = 1'b0;
        auto_step = 1'b1;
`endif

        tick(); tick();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
